instr_stream_loader: RTL and testbench

Reverse of the instruction field splitter. Accepts decoded MIPS32 fields (op, rs, rt, rd, immediate) over a valid/ready handshake and packs each set into a 32-bit instruction word. Buffers the packed words in a small FIFO, then writes them to instruction memory at consecutive word addresses. Used by the testbench/boot path to load programs into instruction memory before the CPU runs.

---
 rtl/instr_pack_pkg.sv | 50 +++++
 rtl/instr_fifo.sv | 48 ++++
 rtl/instr_stream_loader.sv | 116 +++++++++++
 tb/tb_instr_stream_loader.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_pack_pkg.sv
// Shared constants for the instruction stream loader: opcodes, field positions,
// FSM state encoding and the field-packing helper.
package instr_pack_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;

  localparam int unsigned DEFAULT_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // R-type keeps rd plus shamt/funct in imm[10:0]; otherwise the full 16-bit immediate.
  function automatic logic [INSTR_W-1:0] pack_instr(
    input logic        fmt_r,
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm
  );
    logic [INSTR_W-1:0] word;
    word = '0;
    word[OP_LSB +: 6] = op;
    word[RS_LSB +: 5] = rs;
    word[RT_LSB +: 5] = rt;
    if (fmt_r) begin
      word[RD_LSB +: 5] = rd;
      word[10:0]        = imm[10:0];
    end else begin
      word[15:0] = imm;
    end
    return word;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO with registered storage; the head is never bypassed from a
// same-cycle push.
module instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_stream_loader.sv
// Packs decoded MIPS32 field sets into instruction words and streams them into
// instruction memory at consecutive word addresses.
module instr_stream_loader
  import instr_pack_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [CNT_W-1:0]   word_count,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               fmt_r,
  input  logic [5:0]         op,
  input  logic [4:0]         rs,
  input  logic [4:0]         rt,
  input  logic [4:0]         rd,
  input  logic [15:0]        immediate,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [INSTR_W-1:0] mem_wdata,
  input  logic               mem_ready,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   words_written
);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   accepted_q, accepted_d;
  logic [CNT_W-1:0]   written_q, written_d;

  logic               fifo_full, fifo_empty;
  logic               push, pop;
  logic [INSTR_W-1:0] packed_word;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
    end
  end

  // Handshake and status outputs decode registered state only.
  assign in_ready      = (state_q == ST_LOAD) && !fifo_full && (accepted_q < count_q);
  assign mem_we        = ((state_q == ST_LOAD) || (state_q == ST_DRAIN)) && !fifo_empty;
  assign mem_addr      = base_q + ADDR_W'({written_q, 2'b00});
  assign busy          = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
  assign done          = (state_q == ST_DONE);
  assign words_written = written_q;

  assign push        = in_valid && in_ready;
  assign pop         = mem_we && mem_ready;
  assign packed_word = pack_instr(fmt_r, op, rs, rt, rd, immediate);

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    if (push) accepted_d = accepted_q + CNT_W'(1);
    if (pop)  written_d  = written_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d     = base_addr & ~ADDR_W'(3);
          count_d    = word_count;
          accepted_d = '0;
          written_d  = '0;
          state_d    = (word_count == '0) ? ST_DONE : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (accepted_q == count_q) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (written_q == count_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  instr_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (CLK),
    .rst_i       (RST),
    .push_i      (push),
    .push_data_i (packed_word),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (mem_wdata)
  );

endmodule

// File: tb/tb_instr_stream_loader.sv
// Directed bench for instr_stream_loader: packing, addressing, backpressure,
// zero-length loads, ignored starts, address wrap and mid-load reset.
module tb_instr_stream_loader;
  import instr_pack_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [31:0] base_addr;
  logic [7:0]  word_count;
  logic        in_valid;
  logic        in_ready;
  logic        fmt_r;
  logic [5:0]  op;
  logic [4:0]  rs, rt, rd;
  logic [15:0] immediate;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic        busy;
  logic        done;
  logic [7:0]  words_written;

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];

  instr_stream_loader dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .base_addr     (base_addr),
    .word_count    (word_count),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .fmt_r         (fmt_r),
    .op            (op),
    .rs            (rs),
    .rt            (rt),
    .rd            (rd),
    .immediate     (immediate),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ready     (mem_ready),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #5 CLK = ~CLK;

  // Record every completed memory write and every done cycle.
  always @(posedge CLK) begin
    if (mem_we && mem_ready) begin
      wa.push_back(mem_addr);
      wd.push_back(mem_wdata);
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [7:0] n);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic set_fields(input logic f, input logic [5:0] o, input logic [4:0] s,
                            input logic [4:0] t, input logic [4:0] d, input logic [15:0] im);
    fmt_r = f; op = o; rs = s; rt = t; rd = d; immediate = im;
  endtask

  task automatic send(input string tag, input logic f, input logic [5:0] o, input logic [4:0] s,
                      input logic [4:0] t, input logic [4:0] d, input logic [15:0] im);
    logic ok;
    set_fields(f, o, s, t, d, im);
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 64 && !ok; n++) begin
      ok = in_ready;
      step();
    end
    in_valid = 1'b0;
    check({tag, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (done) ok = 1'b1;
      else step();
    end
    check({tag, "_done_seen"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int k;
    int d0;
    logic acc;

    RST = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; mem_ready = 1'b1;
    set_fields(1'b0, 6'h0, 5'h0, 5'h0, 5'h0, 16'h0);
    step(); step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_words_written", 32'(words_written), 32'd0);
    RST = 1'b0;
    step();

    // R-type single word
    wa.delete(); wd.delete(); d0 = done_cnt;
    do_start(32'h0000_0040, 8'd1);
    check("rtype_busy", 32'(busy), 32'd1);
    send("rtype", 1'b1, OP_RTYPE, 5'd1, 5'd2, 5'd3, 16'h0020);
    wait_done("rtype");
    check("rtype_busy_in_done", 32'(busy), 32'd0);
    step();
    check("rtype_done_one_cycle", 32'(done), 32'd0);
    check("rtype_nwrites", 32'(wa.size()), 32'd1);
    check("rtype_addr", wa[0], 32'h0000_0040);
    check("rtype_data", wd[0], 32'h0022_1820);
    check("rtype_words_written", 32'(words_written), 32'd1);
    check("rtype_done_pulses", 32'(done_cnt - d0), 32'd1);

    // I-type pair
    wa.delete(); wd.delete();
    do_start(32'h0, 8'd2);
    send("addi", 1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'd8);
    send("lw", 1'b0, OP_LW, 5'd1, 5'd2, 5'd0, 16'd4);
    wait_done("itype");
    step();
    check("itype_nwrites", 32'(wa.size()), 32'd2);
    check("itype_addr0", wa[0], 32'h0);
    check("itype_data0", wd[0], 32'h2001_0008);
    check("itype_addr1", wa[1], 32'h4);
    check("itype_data1", wd[1], 32'h8C22_0004);
    check("itype_words_written", 32'(words_written), 32'd2);

    // Backpressure: memory stalled for 10 cycles with fields always offered
    wa.delete(); wd.delete();
    mem_ready = 1'b0;
    do_start(32'h0000_0100, 8'd6);
    k = 0;
    in_valid = 1'b1;
    for (int n = 0; n < 10; n++) begin
      set_fields(1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'(k));
      acc = in_ready;
      step();
      if (acc) k++;
    end
    check("bp_accepted", 32'(k), 32'd4);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    check("bp_mem_we", 32'(mem_we), 32'd1);
    check("bp_mem_addr", mem_addr, 32'h0000_0100);
    check("bp_mem_wdata", mem_wdata, 32'h2001_0000);
    check("bp_no_writes", 32'(wa.size()), 32'd0);
    mem_ready = 1'b1;
    for (int n = 0; n < 40 && k < 6; n++) begin
      set_fields(1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'(k));
      acc = in_ready;
      step();
      if (acc) k++;
    end
    in_valid = 1'b0;
    wait_done("bp");
    step();
    check("bp_nwrites", 32'(wa.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("bp_addr%0d", i), wa[i], 32'h0000_0100 + 32'(4 * i));
      check($sformatf("bp_data%0d", i), wd[i], 32'h2001_0000 + 32'(i));
    end
    check("bp_words_written", 32'(words_written), 32'd6);

    // Zero-length load
    wa.delete(); wd.delete(); d0 = done_cnt;
    do_start(32'h0000_0080, 8'd0);
    check("zero_done", 32'(done), 32'd1);
    check("zero_busy", 32'(busy), 32'd0);
    check("zero_mem_we", 32'(mem_we), 32'd0);
    step();
    check("zero_done_clear", 32'(done), 32'd0);
    check("zero_no_writes", 32'(wa.size()), 32'd0);
    check("zero_words_written", 32'(words_written), 32'd0);
    check("zero_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Start while busy is ignored
    wa.delete(); wd.delete(); d0 = done_cnt;
    do_start(32'h0000_0200, 8'd1);
    do_start(32'h0000_0300, 8'd3);
    send("busy_start", 1'b0, OP_SW, 5'd4, 5'd5, 5'd0, 16'h0010);
    wait_done("busy_start");
    step();
    check("busy_start_nwrites", 32'(wa.size()), 32'd1);
    check("busy_start_addr", wa[0], 32'h0000_0200);
    check("busy_start_data", wd[0], 32'hAC85_0010);
    check("busy_start_words_written", 32'(words_written), 32'd1);
    check("busy_start_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Address wrap at the top of the byte address space
    wa.delete(); wd.delete();
    do_start(32'hFFFF_FFFC, 8'd2);
    send("wrap0", 1'b0, OP_BEQ, 5'd1, 5'd2, 5'd0, 16'hFFFF);
    send("wrap1", 1'b0, OP_J, 5'd0, 5'd0, 5'd0, 16'h0001);
    wait_done("wrap");
    step();
    check("wrap_nwrites", 32'(wa.size()), 32'd2);
    check("wrap_addr0", wa[0], 32'hFFFF_FFFC);
    check("wrap_addr1", wa[1], 32'h0000_0000);
    check("wrap_data0", wd[0], 32'h1022_FFFF);
    check("wrap_data1", wd[1], 32'h0800_0001);

    // Reset in the middle of a load
    wa.delete(); wd.delete(); d0 = done_cnt;
    do_start(32'h0000_0400, 8'd5);
    send("mid0", 1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'd1);
    send("mid1", 1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'd2);
    send("mid2", 1'b0, OP_ADDI, 5'd0, 5'd1, 5'd0, 16'd3);
    for (int n = 0; n < 20 && wa.size() < 2; n++) step();
    check("mid_two_written", 32'(words_written), 32'd2);
    RST = 1'b1;
    step();
    check("mid_rst_mem_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_words_written", 32'(words_written), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_mem_addr", mem_addr, 32'h0);
    RST = 1'b0;
    step(); step();
    check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
    wa.delete(); wd.delete();
    do_start(32'h0000_0500, 8'd1);
    send("post_rst", 1'b1, OP_RTYPE, 5'd7, 5'd8, 5'd9, 16'h002A);
    wait_done("post_rst");
    step();
    check("post_rst_nwrites", 32'(wa.size()), 32'd1);
    check("post_rst_addr", wa[0], 32'h0000_0500);
    check("post_rst_data", wd[0], 32'h00E8_482A);
    check("post_rst_words_written", 32'(words_written), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
